// File: rtl/serial_add.sv
// Bit-serial adder: one full-adder slice processes an operand pair LSB-first, one bit per clock.
// Optional macro SERIAL_ADD_SUB_EN adds a `sub` input that turns the operation into a - b.
module serial_add #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             c;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] b_load;
    logic             c_load;

    function automatic logic fa_sum(input logic x, input logic y, input logic ci);
        return x ^ y ^ ci;
    endfunction

    function automatic logic fa_carry(input logic x, input logic y, input logic ci);
        return (x & y) | (x & ci) | (y & ci);
    endfunction

    // New sum bit enters at the MSB; written this way so WIDTH=1 needs no special slice.
    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] v, input logic bit_in);
        logic [WIDTH-1:0] r;
        r = v >> 1;
        r[WIDTH-1] = bit_in;
        return r;
    endfunction

`ifdef SERIAL_ADD_SUB_EN
    // Subtraction as a + ~b + 1; cout then reads as "no borrow".
    always_comb begin
        b_load = sub ? ~b : b;
        c_load = sub ? 1'b1 : cin;
    end
`else
    always_comb begin
        b_load = b;
        c_load = cin;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sum_sh    <= '0;
            c         <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh     <= a;
                        b_sh     <= b_load;
                        c        <= c_load;
                        cnt      <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    sum_sh <= shift_in(sum_sh, fa_sum(a_sh[0], b_sh[0], c));
                    c      <= fa_carry(a_sh[0], b_sh[0], c);
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign sum  = sum_sh;
    assign cout = c;

endmodule

// File: doc/serial_add.md
# serial_add

Bit-serial ripple adder built around the 1-bit full-adder cell. Two WIDTH-bit operands are accepted in one handshake and fed LSB-first through a single full-adder slice. The slice's carry-out is registered and fed back as the next bit's carry-in, and sum bits are collected in a shift register. The block sits downstream of the full-adder cell, consumes its `sum`/`cout` every cycle, and presents a whole word plus final carry with a valid/ready handshake.

## Interface
- `WIDTH`, default 8: operand/result width in bits; legal range ≥1.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: operand word valid.
- `in_ready` out 1: block can accept operands.
- `a` in WIDTH: operand A, sampled on the input handshake.
- `b` in WIDTH: operand B, sampled on the input handshake.
- `cin` in 1: initial carry-in, sampled on the input handshake.
- `out_valid` out 1: `sum`/`cout` valid.
- `out_ready` in 1: downstream accepts the result.
- `sum` out WIDTH: result word.
- `cout` out 1: final carry out of bit WIDTH-1.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - RUN: one bit per cycle.
  - DONE: `out_valid`=1.
- IDLE → RUN when `in_valid && in_ready`.
  - `a` and `b` load into shift registers.
  - `cin` loads into the carry register.
  - Bit counter is cleared to 0.
- Each RUN cycle:
  - Compute s = a_sh[0]^b_sh[0]^c and c' = majority(a_sh[0], b_sh[0], c).
  - Shift `a` and `b` right.
  - sum_sh <= {s, sum_sh[WIDTH-1:1]}.
  - c <= c'.
  - Counter increments.
- RUN → DONE after the cycle that processes bit WIDTH-1 (counter == WIDTH-1).
- `sum` = sum_sh and `cout` = c. Both are registered and stable for the whole DONE period.
- DONE → IDLE when `out_valid && out_ready`.
- `in_ready` is 1 only in IDLE. No new operand is accepted in RUN or DONE, even when `out_ready` is high.
- Arithmetic: {cout, sum} = a + b + cin, computed modulo 2^(WIDTH+1). No saturation.
- Inputs `a`, `b`, `cin` are don't-care outside the input handshake cycle.
- `out_ready` is ignored outside DONE.

## Timing
- Reset values:
  - state = IDLE, so `in_ready`=1.
  - `out_valid`=0, `sum`=0, `cout`=0.
  - Counter = 0, carry = 0.
- Reset takes priority over every other event. `rst` high in RUN or DONE aborts the operation; the next cycle shows the reset values and the partial result is discarded.
- Input handshake in cycle T:
  - RUN occupies cycles T+1 … T+WIDTH.
  - `out_valid` rises at T+WIDTH+1.
  - Latency is WIDTH+1 cycles.
- Output handshake in cycle D: `out_valid`=0 and `in_ready`=1 at D+1. Minimum initiation interval is WIDTH+2 cycles.
- WIDTH=1: exactly one RUN cycle.
- `in_valid` high while `in_ready`=0 has no effect.
- `out_valid` is never withdrawn without a handshake or a reset.

## Configuration
- Macro `SERIAL_ADD_SUB_EN`.
- Defined:
  - Adds input port `sub` (1 bit), sampled on the input handshake.
  - When `sub`=1, `b` is loaded inverted and the carry register is loaded with 1; `cin` is ignored.
  - Result is `sum` = a − b mod 2^WIDTH.
  - `cout`=1 means no borrow (a ≥ b, unsigned).
  - When `sub`=0, behaviour is identical to the undefined case.
- Undefined: no `sub` port; add only.

## Test plan
- WIDTH=8, a=8'hFF, b=8'h01, cin=0, handshake at T → `out_valid`=1 at T+9, `sum`=8'h00, `cout`=1.
- a=8'hA5, b=8'h5A, cin=1 with `out_ready` held low 5 cycles after `out_valid`:
  - `sum`=8'h00 and `cout`=1 held stable throughout.
  - `in_ready`=0 throughout.
  - After `out_ready`=1, `in_ready`=1 next cycle.
- `rst` pulsed during RUN while bit 3 is processed → next cycle `in_ready`=1, `out_valid`=0, `sum`=0, `cout`=0. A fresh 8'h03+8'h04 then yields 8'h07, `cout`=0.
- Back-to-back words with `in_valid` held high and `out_ready`=1 → 8'h12+8'h34 gives 8'h46, then 8'h80+8'h80 gives 8'h00 with `cout`=1. Second accept occurs exactly 10 cycles after the first.
- With `SERIAL_ADD_SUB_EN`:
  - `sub`=1, a=8'h10, b=8'h01 → `sum`=8'h0F, `cout`=1.
  - `sub`=1, a=8'h00, b=8'h01 → `sum`=8'hFF, `cout`=0.
- WIDTH=1, a=1, b=1, cin=1 → `sum`=1, `cout`=1, `out_valid` two cycles after the handshake.
